// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, default line rate and bit-period helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

    localparam int DEFAULT_CLOCK_HZ = 100_000_000;
    localparam int DEFAULT_BAUD     = 115_200;

    function automatic int clks_per_bit(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period counter with synchronous clear; one-cycle tick on the last count.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic clear,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT);

    logic [W-1:0] count;

    assign tick = !clear && count == W'(CLKS_PER_BIT - 1);

    always_ff @(posedge CLOCK or posedge RESET)
        if (RESET)
            count <= '0;
        else
            count <= (clear || tick) ? '0 : count + 1'b1;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready byte in, 8N1 serial out (LSB first, idle high).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
    parameter int CLOCK_HZ  = uart_pkg::DEFAULT_CLOCK_HZ,
    parameter int BAUD      = uart_pkg::DEFAULT_BAUD,
    parameter int DATA_BITS = 8
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [DATA_BITS-1:0] DATA,
    input  logic                 VALID,
    output logic                 READY,
    output logic                 TX,
    output logic                 BUSY
);

    import uart_pkg::*;

    localparam int CPB = clks_per_bit(CLOCK_HZ, BAUD);
    localparam int BW  = $clog2(DATA_BITS);

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx: CLOCK_HZ / BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
        $error("uart_tx: DATA_BITS must be 5..8");
    end

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift;
    logic [BW-1:0]        bit_cnt;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    baud_tick_gen #(.CLKS_PER_BIT(CPB)) u_baud (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .clear(state == IDLE),
        .tick (tick)
    );

    assign BUSY = ~READY;

    // The port DATA shadows the enum literal, so the data state is scoped explicitly.
    always_ff @(posedge CLOCK or posedge RESET)
        if (RESET) begin
            state   <= IDLE;
            TX      <= 1'b1;
            READY   <= 1'b1;
            shift   <= '0;
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (VALID) begin
                    shift  <= DATA;
                    state  <= START;
                    TX     <= 1'b0;
                    READY  <= 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity <= ^DATA;
`endif
                end
                START: if (tick) begin
                    state   <= uart_pkg::DATA;
                    TX      <= shift[0];
                    bit_cnt <= '0;
                end
                uart_pkg::DATA: if (tick) begin
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        TX    <= parity;
`else
                        state <= STOP;
                        TX    <= 1'b1;
`endif
                    end else begin
                        shift   <= shift >> 1;
                        TX      <= shift[1];
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (tick) begin
                    state <= STOP;
                    TX    <= 1'b1;
                end
`endif
                STOP: if (tick) begin
                    state <= IDLE;
                    READY <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    TX    <= 1'b1;
                    READY <= 1'b1;
                end
            endcase
        end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and randomized frame checks of uart_tx against a bit-list line model.
module tb_uart_tx;

    localparam int CLOCK_HZ  = 100;
    localparam int BAUD      = 10;
    localparam int CPB       = CLOCK_HZ / BAUD;
    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DATA_BITS + 3;
`else
    localparam int NBITS = DATA_BITS + 2;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       VALID = 1'b0;
    logic [7:0] DATA  = 8'h00;
    logic       READY, TX, BUSY;

    uart_tx #(.CLOCK_HZ(CLOCK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS)) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .DATA (DATA),
        .VALID(VALID),
        .READY(READY),
        .TX   (TX),
        .BUSY (BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];
    bit got_q[$];
    int ready_low;
    int busy_bad;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Expected line: one entry per clock, each frame bit held for CPB clocks.
    function automatic void push_frame(input logic [7:0] d, input logic p);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_BITS; i++) bits.push_back(d[i]);
        if (NBITS == DATA_BITS + 3) bits.push_back(p);
        bits.push_back(1'b1);
        foreach (bits[b]) repeat (CPB) exp_q.push_back(bits[b]);
    endfunction

    function automatic void push_idle(input int n);
        repeat (n) exp_q.push_back(1'b1);
    endfunction

    function automatic int first_diff();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (got_q[i]) if (got_q[i] != exp_q[i]) return i;
        return -1;
    endfunction

    function automatic void clear_q();
        got_q.delete();
        exp_q.delete();
        ready_low = 0;
        busy_bad  = 0;
    endfunction

    // Samples n negedges; VALID is driven high with vd for sample indices [vf, vt).
    task automatic capture(input int n, input int vf, input int vt, input logic [7:0] vd);
        for (int i = 0; i < n; i++) begin
            got_q.push_back(TX);
            if (!READY) ready_low++;
            if (BUSY !== ~READY) busy_bad++;
            VALID = (i >= vf && i < vt);
            if (VALID) DATA = vd;
            @(negedge CLOCK);
        end
        VALID = 1'b0;
    endtask

    // Leaves the bench at the negedge just after the accept edge (frame cycle 0).
    task automatic start_send(input logic [7:0] d);
        int t = 0;
        while (!READY && t < 500) begin
            @(negedge CLOCK);
            t++;
        end
        if (!READY) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: READY still %0d after %0d cycles", READY, t);
        end
        DATA  = d;
        VALID = 1'b1;
        @(negedge CLOCK);
        VALID = 1'b0;
        clear_q();
    endtask

    task automatic frame_test(input string name, input logic [7:0] d, input logic p);
        start_send(d);
        push_frame(d, p);
        push_idle(1);
        capture(FRAME + 1, 0, 0, 8'h00);
        check({name, " line_first_diff"}, first_diff(), -1);
        check({name, " ready_low_cycles"}, ready_low, FRAME);
        check({name, " busy_vs_ready"}, busy_bad, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad;
        int idx;
        logic [7:0] d;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'h81, 1'b0};
        vecs[4] = '{8'h00, 1'b0};
        vecs[5] = '{8'hFF, 1'b0};
        vecs[6] = '{8'h01, 1'b1};
        vecs[7] = '{8'h80, 1'b1};

        RESET = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge CLOCK);
            if (TX !== 1'b1 || READY !== 1'b1 || BUSY !== 1'b0) bad++;
            VALID = 1'($urandom);
            DATA  = 8'($urandom);
        end
        check("reset_outputs_bad_cycles", bad, 0);
        VALID = 1'b0;
        RESET = 1'b0;
        @(negedge CLOCK);
        check("post_reset_tx", TX, 1);
        check("post_reset_ready", READY, 1);

        foreach (vecs[v]) frame_test($sformatf("vec%0d_%02h", v, vecs[v].data), vecs[v].data, vecs[v].par);

        start_send(8'h00);
        push_frame(8'h00, 1'b0);
        push_idle(1);
        push_frame(8'hFF, 1'b0);
        push_idle(1);
        capture(2 * FRAME + 2, 0, 2 * FRAME, 8'hFF);
        check("b2b line_first_diff", first_diff(), -1);
        check("b2b ready_low_cycles", ready_low, 2 * FRAME);
        idx = -1;
        for (int i = FRAME; i < got_q.size(); i++)
            if (idx < 0 && got_q[i] == 1'b0) idx = i;
        check("b2b second_start_cycle", idx, FRAME + 1);

        start_send(8'h5A);
        push_frame(8'h5A, 1'b0);
        push_idle(20);
        capture(FRAME + 20, 30, 31, 8'h3C);
        check("holdoff line_first_diff", first_diff(), -1);
        check("holdoff ready_low_cycles", ready_low, FRAME);
        check("holdoff busy_vs_ready", busy_bad, 0);

        start_send(8'h00);
        repeat (4 * CPB + CPB / 2) @(negedge CLOCK);
        check("midframe tx_before_reset", TX, 0);
        check("midframe busy_before_reset", BUSY, 1);
        #2 RESET = 1'b1;
        #1;
        check("midframe async_tx", TX, 1);
        check("midframe async_ready", READY, 1);
        check("midframe async_busy", BUSY, 0);
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        clear_q();
        push_idle(15);
        capture(15, 0, 0, 8'h00);
        check("after_reset idle_first_diff", first_diff(), -1);
        check("after_reset ready_low_cycles", ready_low, 0);
        frame_test("after_reset_81", 8'h81, 1'b0);

        for (int r = 0; r < 6; r++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge CLOCK);
            frame_test($sformatf("rand%0d_%02h", r, d), d, 1'($countones(d) % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
